ds96_seq: RTL and testbench
===========================

Name: ds96_seq

Overview:
Sequencer for the 256-to-96 pixel-select downscaler datapath. It accepts a raster pixel stream through a valid/ready handshake and tracks the 8x8 block phase. It drives the datapath's phase, line-buffer address and emit strobes. It presents each downscaled pixel downstream with position flags and backpressure, so the datapath no longer free-runs on an unqualified clock.

Parameters:
IMG_W, 256, input line width in pixels; must be a multiple of 8; output width OUT_W = 3*IMG_W/8 (96).
IMG_H, 256, input rows per frame; must be a multiple of 8; output height OUT_H = 3*IMG_H/8 (96).

Ports:
clk  in  1  clock.
rst  in  1  asynchronous active-high reset.
enable  in  1  allows a new frame to start from IDLE.
s_valid  in  1  input pixel valid.
s_sof  in  1  start-of-frame marker, qualified by s_valid.
s_ready  out  1  input pixel accepted when s_valid && s_ready.
dp_en  out  1  datapath advance strobe, = s_valid && s_ready && effective pixel in frame.
dp_xph  out  3  x phase (effective x mod 8).
dp_yph  out  3  y phase (effective y mod 8).
dp_addr  out  7  line-buffer slot index, 0..OUT_W-1.
dp_emit  out  1  this pixel produces an output: dp_en && xph in {1,5,7} && yph in {1,5,7}.
m_valid  out  1  downscaled pixel valid (datapath dout registered with it).
m_ready  in  1  downstream accept.
m_sol, m_eol, m_eof  out  1 each  output column 0 / column OUT_W-1 / last pixel of frame.
busy  out  1  state != IDLE.
frame_done  out  1  one-cycle pulse.
sof_err  out  1  one-cycle pulse on mid-frame s_sof.

Behaviour:
- Reset state: all outputs 0, x=y=0, state IDLE.
- Effective position (ex, ey):
  - (0,0) when s_sof=1.
  - Otherwise the internal (x,y).
  - dp_xph, dp_yph and dp_addr are combinational from (ex, ey).
- Slot index: dp_addr = 3*(ex>>3) + slot.
  - slot = 0 for xph 0..1.
  - slot = 1 for xph 2..5.
  - slot = 2 for xph 6..7.
- Output coordinates: output column = dp_addr at emit. Output row = 3*(ey>>3) + (yph==1 ? 0 : yph==5 ? 1 : 2).
- Counters advance on each accepted in-frame pixel:
  - x wraps IMG_W-1 -> 0 and increments y.
  - y wraps IMG_H-1 -> 0.
- Stall rule: s_ready = 0 whenever m_valid && !m_ready. Consequently, no emit can occur while an output is held.
- State IDLE (s_ready = 1):
  - Pixel with s_sof=1 and enable=1: processed as (0,0), dp_en=1, next state RUN, x=1.
  - Pixel without s_sof, or with enable=0: consumed and dropped, dp_en=0.
- State RUN (s_ready = !(m_valid && !m_ready)):
  - Accepted pixel with s_sof=1 at (x,y) != (0,0): sof_err pulses next cycle, pixel processed as (0,0), counters restart (x=1, y=0).
  - Accepted pixel at (IMG_W-1, IMG_H-1): next state DRAIN.
  - enable has no effect in RUN.
- State DRAIN (s_ready = 0): on m_valid && m_ready, next state IDLE and frame_done=1 for the following cycle.
- Output register:
  - m_valid sets the cycle after dp_emit. It holds, with flags stable, until m_valid && m_ready.
  - A new emit on the handshake cycle keeps m_valid=1 and loads the new flags.
  - m_sol = (col==0), m_eol = (col==OUT_W-1), m_eof = m_eol && (row==OUT_H-1).
- Latency: 1 cycle from the emitting input handshake to m_valid.
- Rate: 9 outputs per 64 inputs; OUT_W*OUT_H = 9216 outputs per frame.
- Reset asserted mid-frame clears everything immediately; the datapath's partial sums are discarded implicitly because the next frame starts with initialising phases (yph 0/6 rows write, not accumulate).

Decomposition:
- Shared package ds96_pkg:
  - state encoding IDLE/RUN/DRAIN.
  - emit-phase test function (phase in {1,5,7}).
  - slot function of xph.
  - OUT_W/OUT_H derivation.
- One natural sub-module, ds96_phase_cnt: x/y counters, effective-position mux, dp_addr/row computation.
- FSM and output register stay in ds96_seq.

Test Plan:
1. Full 256x256 frame, s_valid and m_ready always 1 -> exactly 9216 m_valid handshakes. First m_valid comes 1 cycle after input (1,1), with m_sol=1. m_eof only on the last handshake. frame_done pulses once, 1 cycle after it.
2. Row y=1, x=0..15 -> dp_addr 0,0,1,1,1,1,2,2,3,3,4,4,4,4,5,5. dp_emit at x=1,5,7,9,13,15.
3. m_ready held 0 for 5 cycles at the first output -> s_ready=0 and dp_en=0 for those 5 cycles, m_valid and flags stable. Resumes with no lost or duplicated output (count still 9216).
4. s_sof at (37,10) -> sof_err pulse, that pixel has dp_xph=0, dp_yph=0, dp_addr=0. The following frame completes with 9216 outputs.
5. rst pulse at (100,50) -> all outputs 0 and busy=0 the same cycle. A subsequent full frame passes case 1 checks.
6. enable=0 with s_sof pixels in IDLE -> dp_en stays 0, busy=0. Non-sof pixels in IDLE with enable=1 are dropped until the first s_sof.

Source files
------------

// File: rtl/ds96_pkg.sv
// Shared definitions for the 256-to-96 pixel-select downscaler sequencer.
package ds96_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } state_e;

  // Output dimension for an input dimension: 3 kept pixels out of every 8.
  function automatic int unsigned out_dim(input int unsigned n);
    return (3 * n) / 8;
  endfunction

  // Phases 1, 5 and 7 close a pixel-select group and produce an output.
  function automatic logic is_emit_ph(input logic [2:0] ph);
    return (ph == 3'd1) || (ph == 3'd5) || (ph == 3'd7);
  endfunction

  // Line-buffer slot within an 8-pixel block: 0..1 -> 0, 2..5 -> 1, 6..7 -> 2.
  function automatic logic [1:0] slot_of(input logic [2:0] xph);
    if (xph <= 3'd1) begin
      return 2'd0;
    end else if (xph <= 3'd5) begin
      return 2'd1;
    end else begin
      return 2'd2;
    end
  endfunction

endpackage

// File: rtl/ds96_phase_cnt.sv
// Raster position counters, effective-position mux and slot/row computation.
module ds96_phase_cnt
  import ds96_pkg::*;
#(
  parameter int unsigned IMG_W = 256,
  parameter int unsigned IMG_H = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       adv,
  input  logic       sof,
  output logic [2:0] xph,
  output logic [2:0] yph,
  output logic [6:0] addr,
  output logic [6:0] row,
  output logic       at_origin,
  output logic       at_last
);

  localparam int unsigned XW = $clog2(IMG_W);
  localparam int unsigned YW = $clog2(IMG_H);

  logic [XW-1:0] x_q, x_d, ex;
  logic [YW-1:0] y_q, y_d, ey;
  logic [1:0]    row_off;

  // A start-of-frame pixel is always treated as position (0,0).
  always_comb begin
    ex        = sof ? '0 : x_q;
    ey        = sof ? '0 : y_q;
    xph       = ex[2:0];
    yph       = ey[2:0];
    row_off   = 2'd2;
    if (yph == 3'd1) begin
      row_off = 2'd0;
    end else if (yph == 3'd5) begin
      row_off = 2'd1;
    end
    addr      = 7'(3 * 32'(ex >> 3)) + 7'(slot_of(xph));
    row       = 7'(3 * 32'(ey >> 3)) + 7'(row_off);
    at_origin = (x_q == '0) && (y_q == '0);
    at_last   = (ex == XW'(IMG_W - 1)) && (ey == YW'(IMG_H - 1));
  end

  // Next position after the effective one, wrapping at line and frame end.
  always_comb begin
    x_d = ex + XW'(1);
    y_d = ey;
    if (ex == XW'(IMG_W - 1)) begin
      x_d = '0;
      y_d = (ey == YW'(IMG_H - 1)) ? '0 : ey + YW'(1);
    end
  end

  // Counters move only on an accepted in-frame pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
    end else if (adv) begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

endmodule

// File: rtl/ds96_seq.sv
// Sequencer for the 256-to-96 downscaler: input handshake, block phase, output register.
module ds96_seq
  import ds96_pkg::*;
#(
  parameter int unsigned IMG_W = 256,
  parameter int unsigned IMG_H = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       s_valid,
  input  logic       s_sof,
  output logic       s_ready,
  output logic       dp_en,
  output logic [2:0] dp_xph,
  output logic [2:0] dp_yph,
  output logic [6:0] dp_addr,
  output logic       dp_emit,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       m_sol,
  output logic       m_eol,
  output logic       m_eof,
  output logic       busy,
  output logic       frame_done,
  output logic       sof_err
);

  localparam int unsigned OUT_W = out_dim(IMG_W);
  localparam int unsigned OUT_H = out_dim(IMG_H);

  state_e     state_q;
  logic       m_valid_q, m_sol_q, m_eol_q, m_eof_q;
  logic       sof_err_q, frame_done_q;
  logic       stall, accept, in_frame;
  logic       at_origin, at_last;
  logic [6:0] out_row;

  ds96_phase_cnt #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_phase_cnt (
    .clk       (clk),
    .rst       (rst),
    .adv       (dp_en),
    .sof       (s_sof),
    .xph       (dp_xph),
    .yph       (dp_yph),
    .addr      (dp_addr),
    .row       (out_row),
    .at_origin (at_origin),
    .at_last   (at_last)
  );

  // Handshake and datapath strobes; a held output blocks input so no emit can be lost.
  always_comb begin
    stall    = m_valid_q && !m_ready;
    s_ready  = !rst && !stall && (state_q != StDrain);
    accept   = s_valid && s_ready;
    in_frame = (state_q == StRun) || ((state_q == StIdle) && s_sof && enable);
    dp_en    = accept && in_frame;
    dp_emit  = dp_en && is_emit_ph(dp_xph) && is_emit_ph(dp_yph);
    busy     = (state_q != StIdle);
  end

  assign m_valid    = m_valid_q;
  assign m_sol      = m_sol_q;
  assign m_eol      = m_eol_q;
  assign m_eof      = m_eof_q;
  assign frame_done = frame_done_q;
  assign sof_err    = sof_err_q;

  // Frame FSM plus registered output flags and status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      m_valid_q    <= 1'b0;
      m_sol_q      <= 1'b0;
      m_eol_q      <= 1'b0;
      m_eof_q      <= 1'b0;
      sof_err_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      sof_err_q    <= (state_q == StRun) && accept && s_sof && !at_origin;
      frame_done_q <= (state_q == StDrain) && m_valid_q && m_ready;
      case (state_q)
        StIdle:  if (dp_en) state_q <= StRun;
        StRun:   if (dp_en && at_last) state_q <= StDrain;
        StDrain: if (m_valid_q && m_ready) state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
      if (dp_emit) begin
        m_valid_q <= 1'b1;
        m_sol_q   <= (dp_addr == 7'd0);
        m_eol_q   <= (dp_addr == 7'(OUT_W - 1));
        m_eof_q   <= (dp_addr == 7'(OUT_W - 1)) && (out_row == 7'(OUT_H - 1));
      end else if (m_ready) begin
        m_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ds96_seq.sv
// Directed bench for ds96_seq on a 256x32 frame (96x12 outputs).
module tb_ds96_seq;

  localparam int W  = 256;
  localparam int H  = 32;
  localparam int OW = 96;
  localparam int OH = 12;

  logic       clk = 1'b0;
  logic       rst, enable, s_valid, s_sof, m_ready;
  logic       s_ready, dp_en, dp_emit, m_valid, m_sol, m_eol, m_eof, busy, frame_done, sof_err;
  logic [2:0] dp_xph, dp_yph;
  logic [6:0] dp_addr;

  ds96_seq #(
    .IMG_W (W),
    .IMG_H (H)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .s_valid    (s_valid),
    .s_sof      (s_sof),
    .s_ready    (s_ready),
    .dp_en      (dp_en),
    .dp_xph     (dp_xph),
    .dp_yph     (dp_yph),
    .dp_addr    (dp_addr),
    .dp_emit    (dp_emit),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_sol      (m_sol),
    .m_eol      (m_eol),
    .m_eof      (m_eof),
    .busy       (busy),
    .frame_done (frame_done),
    .sof_err    (sof_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en, vld, sof;
    logic       e_en, e_emit;
    logic [2:0] e_xph, e_yph;
    logic [6:0] e_addr;
    logic       e_busy;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0, acc_cyc = 0;
  int p = 0;
  int out_cnt, col_e, row_e, first_mv_cyc, last_hs_cyc, fd_cnt, fd_cyc, se_cnt, emit_cyc;
  int stall_left = 0;
  bit stalled = 0, sof_done = 0, se_expect = 0, en_q = 0;
  logic h_sol, h_eol, h_eof;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic mon_clear();
    out_cnt = 0; col_e = 0; row_e = 0; first_mv_cyc = -1; last_hs_cyc = -100;
  endtask

  // Called #1 after a negedge with inputs settled; records activity, then waits a cycle.
  task automatic tick();
    acc_cyc = cyc;
    en_q = dp_en;
    if (m_valid && m_ready) begin
      chk("m_sol", m_sol, int'(col_e == 0));
      chk("m_eol", m_eol, int'(col_e == OW - 1));
      chk("m_eof", m_eof, int'(col_e == OW - 1 && row_e == OH - 1));
      out_cnt++;
      last_hs_cyc = cyc;
      if (col_e == OW - 1) begin col_e = 0; row_e++; end else col_e++;
    end
    if (m_valid && first_mv_cyc < 0) first_mv_cyc = cyc;
    if (frame_done) begin fd_cnt++; fd_cyc = cyc; end
    if (sof_err) se_cnt++;
    @(negedge clk);
    cyc++;
  endtask

  task automatic check_zero(input string pfx);
    chk({pfx, "_s_ready"}, s_ready, 0);
    chk({pfx, "_dp_en"}, dp_en, 0);
    chk({pfx, "_dp_emit"}, dp_emit, 0);
    chk({pfx, "_dp_xph"}, dp_xph, 0);
    chk({pfx, "_dp_yph"}, dp_yph, 0);
    chk({pfx, "_dp_addr"}, dp_addr, 0);
    chk({pfx, "_m_valid"}, m_valid, 0);
    chk({pfx, "_m_flags"}, {m_sol, m_eol, m_eof}, 0);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_frame_done"}, frame_done, 0);
    chk({pfx, "_sof_err"}, sof_err, 0);
  endtask

  task automatic apply_vec(input vec_t v);
    enable = v.en; s_valid = v.vld; s_sof = v.sof; m_ready = 1'b1;
    #1;
    chk("vec_dp_en", dp_en, v.e_en);
    chk("vec_dp_emit", dp_emit, v.e_emit);
    chk("vec_dp_xph", dp_xph, v.e_xph);
    chk("vec_dp_yph", dp_yph, v.e_yph);
    chk("vec_dp_addr", dp_addr, v.e_addr);
    chk("vec_busy", busy, v.e_busy);
    chk("vec_s_ready", s_ready, 1);
    tick();
    if (en_q) p++;
  endtask

  // Streams pixels until p reaches n; optional stall at first output and mid-frame sof.
  task automatic feed(input int n, input bit stall_req, input int sof_at);
    int guard;
    bit inj;
    guard = 0;
    while (p < n && guard < 3 * W * H) begin
      enable = 1'b1; s_valid = 1'b1;
      inj = (sof_at > 0) && !sof_done && (p == sof_at);
      s_sof = (p == 0) || inj;
      if (stall_req && !stalled && m_valid) begin
        stalled = 1; stall_left = 5; h_sol = m_sol; h_eol = m_eol; h_eof = m_eof;
      end
      m_ready = (stall_left == 0);
      #1;
      if (stall_left > 0) begin
        chk("stall_s_ready", s_ready, 0);
        chk("stall_dp_en", dp_en, 0);
        chk("stall_m_valid", m_valid, 1);
        chk("stall_flags", {m_sol, m_eol, m_eof}, {h_sol, h_eol, h_eof});
        stall_left--;
      end
      if (se_expect) begin chk("sof_err_pulse", sof_err, 1); se_expect = 0; end
      if (inj) begin
        chk("sof_dp_xph", dp_xph, 0);
        chk("sof_dp_yph", dp_yph, 0);
        chk("sof_dp_addr", dp_addr, 0);
        chk("sof_dp_en", dp_en, 1);
      end
      tick();
      if (en_q) begin
        if (p == W + 1) emit_cyc = acc_cyc;
        if (inj) begin sof_done = 1; p = 1; mon_clear(); se_expect = 1; end
        else p++;
      end
      guard++;
    end
    chk("feed_progress", p, n);
  endtask

  task automatic run_frame(input bit stall_req, input int sof_at);
    int g;
    mon_clear();
    fd_cnt = 0; se_cnt = 0; stalled = 0; stall_left = 0; sof_done = 0; se_expect = 0;
    emit_cyc = -100; p = 0;
    feed(W * H, stall_req, sof_at);
    s_valid = 1'b0; s_sof = 1'b0; m_ready = 1'b1;
    #1;
    chk("drain_s_ready", s_ready, 0);
    chk("drain_busy", busy, 1);
    tick();
    g = 0;
    while (fd_cnt == 0 && g < 20) begin #1; tick(); g++; end
    #1;
    chk("idle_busy", busy, 0);
    tick();
    chk("out_count", out_cnt, OW * OH);
    chk("frame_done_count", fd_cnt, 1);
    chk("frame_done_lat", fd_cyc - last_hs_cyc, 1);
    chk("first_m_valid_lat", first_mv_cyc - emit_cyc, 1);
    chk("sof_err_count", se_cnt, int'(sof_at > 0));
    if (stall_req) chk("stall_seen", int'(stalled), 1);
  endtask

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    vec_t va[5];
    vec_t vb[16];
    int   b_addr[16] = '{0, 0, 1, 1, 1, 1, 2, 2, 3, 3, 4, 4, 4, 4, 5, 5};
    bit   b_emit[16] = '{0, 1, 0, 0, 0, 1, 0, 1, 0, 1, 0, 0, 0, 1, 0, 1};

    // IDLE: sof with enable low, non-sof with enable high, sof without valid, then a real start.
    va[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 7'd0, 1'b0};
    va[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 7'd0, 1'b0};
    va[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 7'd0, 1'b0};
    va[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 7'd0, 1'b0};
    va[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 7'd0, 1'b0};
    // Row y=1, x=0..15.
    for (int i = 0; i < 16; i++)
      vb[i] = '{1'b1, 1'b1, 1'b0, 1'b1, b_emit[i], 3'(i % 8), 3'd1, 7'(b_addr[i]), 1'b1};

    rst = 1'b1; enable = 1'b0; s_valid = 1'b0; s_sof = 1'b0; m_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    check_zero("reset");
    tick();
    rst = 1'b0;
    #1;
    tick();

    mon_clear();
    fd_cnt = 0; se_cnt = 0; p = 0;
    for (int i = 0; i < 5; i++) apply_vec(va[i]);
    chk("start_p", p, 1);
    feed(W, 0, 0);
    for (int i = 0; i < 16; i++) apply_vec(vb[i]);
    feed(20 * W + 100, 0, 0);

    // Reset mid-frame at (100,20), pixel still offered.
    rst = 1'b1;
    #1;
    check_zero("midrst");
    tick();
    rst = 1'b0; s_valid = 1'b0; s_sof = 1'b0;
    #1;
    tick();

    run_frame(0, 0);
    run_frame(1, 0);
    run_frame(0, 10 * W + 37);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
